// File: rtl/ysyx_23060203_ifu_pkg.sv
// Shared definitions for the NPC pipeline: fetch FSM state encoding,
// reset PC default and the canonical NOP instruction word.
package ysyx_23060203_ifu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2,
    WB    = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  // True when the two low PC bits describe a word-aligned address.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: holds the PC, issues one instruction read at a
// time, hands the fetched word to decode, then waits for the next PC.
// Optional feature macro: YSYX_23060203_IFU_ALIGN_CHECK_EN (misaligned PCs
// skip the memory read and deliver a faulting NOP instead).
module ysyx_23060203_ifu
  import ysyx_23060203_ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT[ADDR_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_err,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dnpc,
  output logic [ADDR_W-1:0] pc
);

  ifu_state_e        state;
  ifu_state_e        state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       inst_q;
  logic [31:0]       inst_d;
  logic              err_q;
  logic              err_d;

  // State register plus the PC and fetched-word holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc_q   <= RESET_PC;
      inst_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      pc_q   <= pc_d;
      inst_q <= inst_d;
      err_q  <= err_d;
    end
  end

  // Next-state logic; responses are only taken in WAIT, next PC only in WB.
  always_comb begin
    state_d        = state;
    pc_d           = pc_q;
    inst_d         = inst_q;
    err_d          = err_q;
    imem_req_valid = 1'b0;
    case (state)
      FETCH: begin
`ifdef YSYX_23060203_IFU_ALIGN_CHECK_EN
        if (!is_word_aligned(pc_q[1:0])) begin
          state_d = OUT;
          inst_d  = NOP_INST;
          err_d   = 1'b1;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            state_d = WAIT;
          end
        end
`else
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = WAIT;
        end
`endif
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          err_d   = imem_rsp_err;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = WB;
        end
      end
      WB: begin
        if (wb_valid) begin
          pc_d    = wb_dnpc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (rst) begin
      imem_req_valid = 1'b0;
    end
  end

  assign imem_req_addr = pc_q;
  assign pc            = pc_q;
  assign out_valid     = (state == OUT);
  assign out_inst      = inst_q;
  assign out_pc        = pc_q;
  assign out_err       = err_q;

endmodule
